// File: rtl/id_ex_stage_pkg.sv
// Shared widths, ALU opcodes and register-index constants for the ID/EX stage.
package id_ex_stage_pkg;

    localparam int XLEN     = 32;
    localparam int ALU_OP_W = 4;
    localparam int CNT_W    = 16;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_LUI  = 4'd10
    } alu_op_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of ID-side inputs, bypass inputs and ID/EX outputs of the ID/EX stage.
interface id_ex_stage_if;
    import id_ex_stage_pkg::*;

    logic                id_valid_i;
    logic [XLEN-1:0]     id_pc_i;
    logic [4:0]          id_rs1_i;
    logic [4:0]          id_rs2_i;
    logic [4:0]          id_rd_i;
    logic [XLEN-1:0]     id_rs1_data_i;
    logic [XLEN-1:0]     id_rs2_data_i;
    logic [XLEN-1:0]     id_imm_i;
    logic [ALU_OP_W-1:0] id_alu_op_i;
    logic                id_use_imm_i;
    logic                id_write_reg_i;
    logic                id_mem_read_i;
    logic                id_mem_write_i;
    logic                flush_i;
    logic                fwd_ex_mem_rs1_i;
    logic                fwd_ex_mem_rs2_i;
    logic                fwd_mem_wb_rs1_i;
    logic                fwd_mem_wb_rs2_i;
    logic [XLEN-1:0]     EX_MEM_alu_result_i;
    logic [XLEN-1:0]     MEM_WB_wb_data_i;

    logic [4:0]          ID_EX_rs1_o;
    logic [4:0]          ID_EX_rs2_o;
    logic [4:0]          ID_EX_rd_o;
    logic [XLEN-1:0]     ID_EX_pc_o;
    logic [ALU_OP_W-1:0] ID_EX_alu_op_o;
    logic                ID_EX_write_reg_o;
    logic                ID_EX_mem_read_o;
    logic                ID_EX_mem_write_o;
    logic [XLEN-1:0]     ex_operand_a_o;
    logic [XLEN-1:0]     ex_operand_b_o;
    logic [XLEN-1:0]     ex_store_data_o;
    logic                stall_o;
    logic [CNT_W-1:0]    bubble_count_o;

    // Decode/forwarding side: drives the ID fields and bypass values.
    modport master (
        output id_valid_i, id_pc_i, id_rs1_i, id_rs2_i, id_rd_i,
               id_rs1_data_i, id_rs2_data_i, id_imm_i, id_alu_op_i,
               id_use_imm_i, id_write_reg_i, id_mem_read_i, id_mem_write_i,
               flush_i, fwd_ex_mem_rs1_i, fwd_ex_mem_rs2_i,
               fwd_mem_wb_rs1_i, fwd_mem_wb_rs2_i,
               EX_MEM_alu_result_i, MEM_WB_wb_data_i,
        input  ID_EX_rs1_o, ID_EX_rs2_o, ID_EX_rd_o, ID_EX_pc_o,
               ID_EX_alu_op_o, ID_EX_write_reg_o, ID_EX_mem_read_o,
               ID_EX_mem_write_o, ex_operand_a_o, ex_operand_b_o,
               ex_store_data_o, stall_o, bubble_count_o
    );

    // The ID/EX stage itself.
    modport slave (
        input  id_valid_i, id_pc_i, id_rs1_i, id_rs2_i, id_rd_i,
               id_rs1_data_i, id_rs2_data_i, id_imm_i, id_alu_op_i,
               id_use_imm_i, id_write_reg_i, id_mem_read_i, id_mem_write_i,
               flush_i, fwd_ex_mem_rs1_i, fwd_ex_mem_rs2_i,
               fwd_mem_wb_rs1_i, fwd_mem_wb_rs2_i,
               EX_MEM_alu_result_i, MEM_WB_wb_data_i,
        output ID_EX_rs1_o, ID_EX_rs2_o, ID_EX_rd_o, ID_EX_pc_o,
               ID_EX_alu_op_o, ID_EX_write_reg_o, ID_EX_mem_read_o,
               ID_EX_mem_write_o, ex_operand_a_o, ex_operand_b_o,
               ex_store_data_o, stall_o, bubble_count_o
    );

endinterface

// File: rtl/id_ex_stage_operand_bypass_mux.sv
// Three-way priority bypass mux: EX/MEM beats MEM/WB beats the register-file value.
module operand_bypass_mux
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = XLEN
) (
    input  logic              sel_ex_mem,
    input  logic              sel_mem_wb,
    input  logic [DATA_W-1:0] ex_mem_val,
    input  logic [DATA_W-1:0] mem_wb_val,
    input  logic [DATA_W-1:0] reg_val,
    output logic [DATA_W-1:0] operand
);

    // Newest producer wins when both forwards are requested.
    always_comb begin
        operand = reg_val;
        if (sel_ex_mem) begin
            operand = ex_mem_val;
        end else if (sel_mem_wb) begin
            operand = mem_wb_val;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection, bubble insertion,
// a saturating bubble counter and the EX operand bypass muxes.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    id_ex_stage_if.slave bus
);

    logic [4:0]          rs1_p1;
    logic [4:0]          rs2_p1;
    logic [4:0]          rd_p1;
    logic [XLEN-1:0]     pc_p1;
    logic [ALU_OP_W-1:0] alu_op_p1;
    logic                write_reg_p1;
    logic                mem_read_p1;
    logic                mem_write_p1;
    logic                use_imm_p1;
    logic [XLEN-1:0]     rs1_data_p1;
    logic [XLEN-1:0]     rs2_data_p1;
    logic [XLEN-1:0]     imm_p1;
    logic [CNT_W-1:0]    bubble_cnt_p1;
    logic                stall;
    logic [XLEN-1:0]     rs2_fwd;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Load-use hazard: the load in EX cannot feed the instruction now in ID.
    // A flush discards the ID instruction, so no stall is needed then.
    always_comb begin
        stall = !reset && mem_read_p1 && (rd_p1 != REG_ZERO) && bus.id_valid_i
                && ((rd_p1 == bus.id_rs1_i) || (rd_p1 == bus.id_rs2_i))
                && !bus.flush_i;
    end

    // ---- ID -> EX register boundary ----
    // Capture the ID instruction, or insert a bubble on flush/stall/empty ID.
    always_ff @(posedge clk) begin
        if (reset) begin
            rs1_p1        <= REG_ZERO;
            rs2_p1        <= REG_ZERO;
            rd_p1         <= REG_ZERO;
            pc_p1         <= '0;
            alu_op_p1     <= '0;
            write_reg_p1  <= 1'b0;
            mem_read_p1   <= 1'b0;
            mem_write_p1  <= 1'b0;
            use_imm_p1    <= 1'b0;
            rs1_data_p1   <= '0;
            rs2_data_p1   <= '0;
            imm_p1        <= '0;
            bubble_cnt_p1 <= '0;
        end else if (bus.flush_i || stall) begin
            rs1_p1        <= REG_ZERO;
            rs2_p1        <= REG_ZERO;
            rd_p1         <= REG_ZERO;
            write_reg_p1  <= 1'b0;
            mem_read_p1   <= 1'b0;
            mem_write_p1  <= 1'b0;
            bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
        end else if (bus.id_valid_i) begin
            rs1_p1        <= bus.id_rs1_i;
            rs2_p1        <= bus.id_rs2_i;
            rd_p1         <= bus.id_rd_i;
            pc_p1         <= bus.id_pc_i;
            alu_op_p1     <= bus.id_alu_op_i;
            write_reg_p1  <= bus.id_write_reg_i;
            mem_read_p1   <= bus.id_mem_read_i;
            mem_write_p1  <= bus.id_mem_write_i;
            use_imm_p1    <= bus.id_use_imm_i;
            rs1_data_p1   <= bus.id_rs1_data_i;
            rs2_data_p1   <= bus.id_rs2_data_i;
            imm_p1        <= bus.id_imm_i;
        end else begin
            // Empty ID slot: uncounted bubble.
            rs1_p1        <= REG_ZERO;
            rs2_p1        <= REG_ZERO;
            rd_p1         <= REG_ZERO;
            write_reg_p1  <= 1'b0;
            mem_read_p1   <= 1'b0;
            mem_write_p1  <= 1'b0;
        end
    end

    // ---- EX operand selection (combinational on the registered data) ----
    operand_bypass_mux #(.DATA_W(XLEN)) u_mux_a (
        .sel_ex_mem (bus.fwd_ex_mem_rs1_i),
        .sel_mem_wb (bus.fwd_mem_wb_rs1_i),
        .ex_mem_val (bus.EX_MEM_alu_result_i),
        .mem_wb_val (bus.MEM_WB_wb_data_i),
        .reg_val    (rs1_data_p1),
        .operand    (bus.ex_operand_a_o)
    );

    operand_bypass_mux #(.DATA_W(XLEN)) u_mux_b (
        .sel_ex_mem (bus.fwd_ex_mem_rs2_i),
        .sel_mem_wb (bus.fwd_mem_wb_rs2_i),
        .ex_mem_val (bus.EX_MEM_alu_result_i),
        .mem_wb_val (bus.MEM_WB_wb_data_i),
        .reg_val    (rs2_data_p1),
        .operand    (rs2_fwd)
    );

    // Drive the registered fields and final operands onto the bus.
    always_comb begin
        bus.ID_EX_rs1_o       = rs1_p1;
        bus.ID_EX_rs2_o       = rs2_p1;
        bus.ID_EX_rd_o        = rd_p1;
        bus.ID_EX_pc_o        = pc_p1;
        bus.ID_EX_alu_op_o    = alu_op_p1;
        bus.ID_EX_write_reg_o = write_reg_p1;
        bus.ID_EX_mem_read_o  = mem_read_p1;
        bus.ID_EX_mem_write_o = mem_write_p1;
        bus.ex_store_data_o   = rs2_fwd;
        bus.ex_operand_b_o    = use_imm_p1 ? imm_p1 : rs2_fwd;
        bus.stall_o           = stall;
        bus.bubble_count_o    = bubble_cnt_p1;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load-use stall, x0 load, bypass
// priority, store operand split, flush-over-hazard and counter saturation.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are changed and outputs read here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic wr, input logic mrd, input logic mwr, input logic uimm,
                             input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                             input logic [31:0] pc);
        bus.id_valid_i     = 1'b1;
        bus.id_rs1_i       = rs1;
        bus.id_rs2_i       = rs2;
        bus.id_rd_i        = rd;
        bus.id_write_reg_i = wr;
        bus.id_mem_read_i  = mrd;
        bus.id_mem_write_i = mwr;
        bus.id_use_imm_i   = uimm;
        bus.id_rs1_data_i  = d1;
        bus.id_rs2_data_i  = d2;
        bus.id_imm_i       = imm;
        bus.id_pc_i        = pc;
        bus.id_alu_op_i    = ALU_ADD;
    endtask

    initial begin
        bus.flush_i             = 1'b0;
        bus.fwd_ex_mem_rs1_i    = 1'b0;
        bus.fwd_ex_mem_rs2_i    = 1'b0;
        bus.fwd_mem_wb_rs1_i    = 1'b0;
        bus.fwd_mem_wb_rs2_i    = 1'b0;
        bus.EX_MEM_alu_result_i = 32'h0;
        bus.MEM_WB_wb_data_i    = 32'h0;
        set_instr(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 32'h11, 32'h22, 32'h4, 32'h100);
        bus.id_alu_op_i = ALU_SUB;

        // Reset for two cycles with a valid instruction presented.
        reset = 1'b1;
        tick();
        tick();
        chk("rst_rd",     {27'd0, bus.ID_EX_rd_o}, 32'd0);
        chk("rst_rs1",    {27'd0, bus.ID_EX_rs1_o}, 32'd0);
        chk("rst_pc",     bus.ID_EX_pc_o, 32'd0);
        chk("rst_aluop",  {28'd0, bus.ID_EX_alu_op_o}, 32'd0);
        chk("rst_wr",     {31'd0, bus.ID_EX_write_reg_o}, 32'd0);
        chk("rst_mrd",    {31'd0, bus.ID_EX_mem_read_o}, 32'd0);
        chk("rst_mwr",    {31'd0, bus.ID_EX_mem_write_o}, 32'd0);
        chk("rst_stall",  {31'd0, bus.stall_o}, 32'd0);
        chk("rst_cnt",    {16'd0, bus.bubble_count_o}, 32'd0);

        // lw x5, 0(x1) followed by add x6, x5, x7.
        reset = 1'b0;
        set_instr(5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1000, 32'h0, 32'h0, 32'h200);
        tick();
        chk("lw_rd",      {27'd0, bus.ID_EX_rd_o}, 32'd5);
        chk("lw_mrd",     {31'd0, bus.ID_EX_mem_read_o}, 32'd1);
        chk("lw_pc",      bus.ID_EX_pc_o, 32'h200);
        set_instr(5'd5, 5'd7, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1111_1111, 32'h7777_7777, 32'h0, 32'h204);
        #1;
        chk("lu_stall",   {31'd0, bus.stall_o}, 32'd1);
        tick();
        chk("lu_bub_wr",  {31'd0, bus.ID_EX_write_reg_o}, 32'd0);
        chk("lu_bub_rd",  {27'd0, bus.ID_EX_rd_o}, 32'd0);
        chk("lu_cnt",     {16'd0, bus.bubble_count_o}, 32'd1);
        chk("lu_stall_0", {31'd0, bus.stall_o}, 32'd0);
        tick();
        chk("add_rd",     {27'd0, bus.ID_EX_rd_o}, 32'd6);
        chk("add_rs1",    {27'd0, bus.ID_EX_rs1_o}, 32'd5);
        chk("add_rs2",    {27'd0, bus.ID_EX_rs2_o}, 32'd7);
        chk("add_wr",     {31'd0, bus.ID_EX_write_reg_o}, 32'd1);
        chk("add_pc",     bus.ID_EX_pc_o, 32'h204);
        chk("add_cnt",    {16'd0, bus.bubble_count_o}, 32'd1);

        // Bypass priority on operand A, and plain register operand B.
        bus.EX_MEM_alu_result_i = 32'hAAAA_0001;
        bus.MEM_WB_wb_data_i    = 32'h5555_0002;
        bus.fwd_ex_mem_rs1_i    = 1'b1;
        bus.fwd_mem_wb_rs1_i    = 1'b1;
        #1;
        chk("opa_both",   bus.ex_operand_a_o, 32'hAAAA_0001);
        bus.fwd_ex_mem_rs1_i    = 1'b0;
        #1;
        chk("opa_memwb",  bus.ex_operand_a_o, 32'h5555_0002);
        bus.fwd_mem_wb_rs1_i    = 1'b0;
        #1;
        chk("opa_reg",    bus.ex_operand_a_o, 32'h1111_1111);
        chk("opb_reg",    bus.ex_operand_b_o, 32'h7777_7777);
        bus.fwd_ex_mem_rs2_i    = 1'b1;
        #1;
        chk("opb_exmem",  bus.ex_operand_b_o, 32'hAAAA_0001);
        bus.fwd_ex_mem_rs2_i    = 1'b0;

        // lw x0 then add x6, x0, x1: no hazard through x0.
        set_instr(5'd2, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h300);
        tick();
        set_instr(5'd0, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h304);
        #1;
        chk("x0_stall",   {31'd0, bus.stall_o}, 32'd0);
        tick();
        chk("x0_add_pc",  bus.ID_EX_pc_o, 32'h304);
        chk("x0_cnt",     {16'd0, bus.bubble_count_o}, 32'd1);

        // sw x3, 8(x2): immediate on B, forwarded rs2 on store data.
        set_instr(5'd2, 5'd3, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 32'h33, 32'd8, 32'h400);
        tick();
        bus.MEM_WB_wb_data_i = 32'hDEAD_BEEF;
        bus.fwd_mem_wb_rs2_i = 1'b1;
        #1;
        chk("sw_mwr",     {31'd0, bus.ID_EX_mem_write_o}, 32'd1);
        chk("sw_opb",     bus.ex_operand_b_o, 32'd8);
        chk("sw_store",   bus.ex_store_data_o, 32'hDEAD_BEEF);
        bus.fwd_mem_wb_rs2_i = 1'b0;
        #1;
        chk("sw_store_r", bus.ex_store_data_o, 32'h33);

        // Flush in the same cycle as a load-use hazard.
        set_instr(5'd1, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h500);
        tick();
        set_instr(5'd4, 5'd9, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h504);
        #1;
        chk("fl_haz",     {31'd0, bus.stall_o}, 32'd1);
        bus.flush_i = 1'b1;
        #1;
        chk("fl_stall",   {31'd0, bus.stall_o}, 32'd0);
        tick();
        chk("fl_wr",      {31'd0, bus.ID_EX_write_reg_o}, 32'd0);
        chk("fl_mrd",     {31'd0, bus.ID_EX_mem_read_o}, 32'd0);
        chk("fl_cnt",     {16'd0, bus.bubble_count_o}, 32'd2);

        // Empty ID slot: bubble that is not counted.
        bus.flush_i    = 1'b0;
        bus.id_valid_i = 1'b0;
        tick();
        chk("idle_wr",    {31'd0, bus.ID_EX_write_reg_o}, 32'd0);
        chk("idle_cnt",   {16'd0, bus.bubble_count_o}, 32'd2);

        // Drive the counter to all-ones with flushes, then one more.
        bus.flush_i = 1'b1;
        repeat (65533) @(posedge clk);
        #1;
        chk("sat_reach",  {16'd0, bus.bubble_count_o}, 32'h0000_FFFF);
        tick();
        chk("sat_hold",   {16'd0, bus.bubble_count_o}, 32'h0000_FFFF);
        bus.flush_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
